// File: rtl/uart_frame_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : uart_frame_scheduler
//  Description : Shares one byte-level UART transmitter between a periodic
//                telemetry report and an asynchronous event report. Latches
//                requests, gives events priority, and emits each winner as a
//                fixed 5-byte frame:
//                  HEADER, type, hi, lo, type ^ hi ^ lo
//                The UART is driven one byte at a time through a
//                tx_start / tx_done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_frame_scheduler #(
  parameter int unsigned REPORT_PERIOD = 5_000_000,
  parameter logic [7:0]  HEADER        = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] tel_data,
  input  logic        evt_req,
  input  logic [7:0]  evt_code,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_done,
  output logic        busy,
  output logic        frame_done,
  output logic        evt_overrun
);

  // Wide enough for the largest legal period (2^24-1).
  localparam int unsigned        TIMER_W    = 24;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(REPORT_PERIOD - 1);
  localparam logic [7:0]         TYPE_TEL   = 8'h01;
  localparam logic [7:0]         TYPE_EVT   = 8'h02;
  localparam logic [2:0]         LAST_IDX   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_SEND = 3'd2,
    ST_WAIT = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t             state;
  logic [TIMER_W-1:0] timer;
  logic               tel_pend;
  logic               evt_pend;
  logic [7:0]         evt_latched;
  logic [2:0]         idx;

  // Payload frozen at LOAD so the in-flight frame is immune to input changes.
  logic [7:0]         frm_type;
  logic [7:0]         frm_hi;
  logic [7:0]         frm_lo;

  logic               wrap;
  logic               load_evt;
  logic               load_tel;
  logic [2:0]         idx_next;
  logic [7:0]         next_byte;

  assign wrap     = enable && (timer == TIMER_LAST);
  assign load_evt = (state == ST_LOAD) &&  evt_pend;
  assign load_tel = (state == ST_LOAD) && !evt_pend;
  assign idx_next = idx + 3'd1;

  // Byte that follows the current one; the checksum is derived from the
  // frozen payload rather than stored.
  always_comb begin
    next_byte = 8'h00;
    case (idx_next)
      3'd0:    next_byte = HEADER;
      3'd1:    next_byte = frm_type;
      3'd2:    next_byte = frm_hi;
      3'd3:    next_byte = frm_lo;
      default: next_byte = frm_type ^ frm_hi ^ frm_lo;
    endcase
  end

  // Report timer: free-runs 0..REPORT_PERIOD-1 while enabled, parked at 0 otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= '0;
    end else if (!enable) begin
      timer <= '0;
    end else if (timer == TIMER_LAST) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  // Telemetry request flag; a wrap while already pending is simply absorbed,
  // and a wrap coinciding with the telemetry LOAD re-arms the flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      tel_pend <= 1'b0;
    end else if (wrap) begin
      tel_pend <= 1'b1;
    end else if (load_tel) begin
      tel_pend <= 1'b0;
    end
  end

  // Event latch: single-entry; a request arriving while the slot is full is
  // dropped and flagged, unless LOAD is emptying the slot in that same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_pend    <= 1'b0;
      evt_latched <= 8'h00;
      evt_overrun <= 1'b0;
    end else if (evt_req) begin
      if (evt_pend && !load_evt) begin
        evt_overrun <= 1'b1;
      end else begin
        evt_pend    <= 1'b1;
        evt_latched <= evt_code;
      end
    end else if (load_evt) begin
      evt_pend <= 1'b0;
    end
  end

  // Frame sequencer with registered outputs: arbitrate, load, then walk the
  // five bytes through the UART handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      tx_data    <= 8'h00;
      tx_start   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      idx        <= 3'd0;
      frm_type   <= 8'h00;
      frm_hi     <= 8'h00;
      frm_lo     <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (evt_pend || tel_pend) begin
            state <= ST_LOAD;
            busy  <= 1'b1;
          end
        end

        ST_LOAD: begin
          if (evt_pend) begin
            frm_type <= TYPE_EVT;
            frm_hi   <= 8'h00;
            frm_lo   <= evt_latched;
          end else begin
            frm_type <= TYPE_TEL;
            frm_hi   <= tel_data[15:8];
            frm_lo   <= tel_data[7:0];
          end
          idx      <= 3'd0;
          tx_data  <= HEADER;
          tx_start <= 1'b1;
          state    <= ST_SEND;
        end

        ST_SEND: begin
          tx_start <= 1'b0;
          state    <= ST_WAIT;
        end

        ST_WAIT: begin
          if (tx_done) begin
            if (idx == LAST_IDX) begin
              frame_done <= 1'b1;
              state      <= ST_DONE;
            end else begin
              idx      <= idx_next;
              tx_data  <= next_byte;
              tx_start <= 1'b1;
              state    <= ST_SEND;
            end
          end
        end

        ST_DONE: begin
          frame_done <= 1'b0;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end

        default: begin
          tx_start   <= 1'b0;
          frame_done <= 1'b0;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_frame_scheduler
//  Description : Directed self-checking bench for uart_frame_scheduler with a
//                small UART responder and a byte/frame logger.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_frame_scheduler;

  localparam int PERIOD = 16;

  logic        clk      = 1'b0;
  logic        rst      = 1'b1;
  logic        enable   = 1'b0;
  logic [15:0] tel_data = 16'h0000;
  logic        evt_req  = 1'b0;
  logic [7:0]  evt_code = 8'h00;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_done;
  logic        busy;
  logic        frame_done;
  logic        evt_overrun;

  logic uart_done   = 1'b0;
  logic manual_done = 1'b0;
  assign tx_done = uart_done | manual_done;

  int uart_delay = 10;
  bit uart_on    = 1'b1;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0] bytes[$];
  int         start_cyc[$];
  int         fdone_cyc[$];

  uart_frame_scheduler #(
    .REPORT_PERIOD(PERIOD),
    .HEADER       (8'hA5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .tel_data   (tel_data),
    .evt_req    (evt_req),
    .evt_code   (evt_code),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_done    (tx_done),
    .busy       (busy),
    .frame_done (frame_done),
    .evt_overrun(evt_overrun)
  );

  always #5 clk = ~clk;

  // Edge counter: value seen after edge k is k.
  always @(posedge clk) cyc <= cyc + 1;

  // Logger sampled on the falling edge.
  always @(negedge clk) begin
    if (tx_start === 1'b1) begin
      bytes.push_back(tx_data);
      start_cyc.push_back(cyc);
    end
    if (frame_done === 1'b1) fdone_cyc.push_back(cyc);
  end

  // UART responder: tx_done sampled uart_delay edges after the SEND->WAIT edge.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1 && uart_on) begin
        @(posedge clk);
        repeat (uart_delay - 1) @(posedge clk);
        #1;
        if (uart_on) uart_done = 1'b1;
        @(posedge clk);
        #1 uart_done = 1'b0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    bytes.delete();
    start_cyc.delete();
    fdone_cyc.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    clear_log();
  endtask

  task automatic wait_frames(input int n, input int budget, output bit ok);
    int k = 0;
    while (fdone_cyc.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    ok = (fdone_cyc.size() >= n);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    checks++;
    if ({tx_start, busy, frame_done, evt_overrun} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl: got start/busy/fdone/ovr=%b required 0000",
               {tx_start, busy, frame_done, evt_overrun});
    end
    checks++;
    if (tx_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_data: got %h required 00", tx_data);
    end
    rst = 1'b0;
    clear_log();
    tick(20);
    checks++;
    if (bytes.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: got %0d starts busy=%b required 0 starts busy=0", bytes.size(), busy);
    end
  endtask

  task automatic test_event_frame();
    logic [7:0] exp [5];
    int e;
    bit ok;
    exp = '{8'hA5, 8'h02, 8'h00, 8'h3C, 8'h3E};
    do_reset();
    enable = 1'b0; uart_on = 1'b1; uart_delay = 10;
    e = cyc;
    evt_req = 1'b1; evt_code = 8'h3C;
    tick(1);
    evt_req = 1'b0; evt_code = 8'h00;
    wait_frames(1, 300, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL evt_timeout: got %0d frames required 1", fdone_cyc.size());
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= bytes.size() || bytes[i] !== exp[i]) begin
        failures++;
        $display("FAIL evt_byte%0d: got %h required %h", i,
                 (i < bytes.size()) ? bytes[i] : 8'hxx, exp[i]);
      end
    end
    checks++;
    if (start_cyc.size() < 5 || start_cyc[0] != e + 3 || start_cyc[1] - start_cyc[0] != 11) begin
      failures++;
      $display("FAIL evt_latency: got first=%0d gap=%0d required first=%0d gap=11",
               (start_cyc.size() > 0) ? start_cyc[0] - e : -1,
               (start_cyc.size() > 1) ? start_cyc[1] - start_cyc[0] : -1, 3);
    end
    tick(20);
    checks++;
    if (fdone_cyc.size() != 1 || bytes.size() != 5 || start_cyc[4] + 11 != fdone_cyc[0]) begin
      failures++;
      $display("FAIL evt_fdone: got %0d frame_done %0d bytes required 1 and 5 (done 11 after last start)",
               fdone_cyc.size(), bytes.size());
    end
    checks++;
    if (evt_overrun !== 1'b0) begin
      failures++;
      $display("FAIL evt_overrun_clear: got %b required 0", evt_overrun);
    end
  endtask

  task automatic test_periodic();
    logic [7:0] exp [5];
    int e;
    bit ok;
    exp = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h27};
    do_reset();
    uart_on = 1'b1; uart_delay = 1;
    tel_data = 16'h1234;
    e = cyc;
    enable = 1'b1;
    wait_frames(2, 120, ok);
    enable = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL tel_timeout: got %0d frames required 2", fdone_cyc.size());
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (i >= bytes.size() || bytes[i] !== exp[i % 5]) begin
        failures++;
        $display("FAIL tel_byte%0d: got %h required %h", i,
                 (i < bytes.size()) ? bytes[i] : 8'hxx, exp[i % 5]);
      end
    end
    checks++;
    if (start_cyc.size() < 6 || start_cyc[0] != e + 18 || start_cyc[5] - start_cyc[0] != PERIOD) begin
      failures++;
      $display("FAIL tel_timing: got first=%0d period=%0d required first=18 period=%0d",
               (start_cyc.size() > 0) ? start_cyc[0] - e : -1,
               (start_cyc.size() > 5) ? start_cyc[5] - start_cyc[0] : -1, PERIOD);
    end
    tick(40);
    checks++;
    if (bytes.size() != 10) begin
      failures++;
      $display("FAIL tel_disable: got %0d bytes required 10", bytes.size());
    end
  endtask

  task automatic test_priority();
    logic [7:0] exp [10];
    int e;
    bit ok;
    exp = '{8'hA5, 8'h02, 8'h00, 8'h5A, 8'h58, 8'hA5, 8'h01, 8'hBE, 8'hEF, 8'h50};
    do_reset();
    uart_on = 1'b1; uart_delay = 1;
    tel_data = 16'hBEEF;
    e = cyc;
    enable = 1'b1;
    tick(15);
    evt_req = 1'b1; evt_code = 8'h5A;
    tick(1);
    evt_req = 1'b0; evt_code = 8'h00; enable = 1'b0;
    wait_frames(2, 100, ok);
    tick(20);
    checks++;
    if (!ok || bytes.size() != 10) begin
      failures++;
      $display("FAIL prio_count: got %0d bytes required 10", bytes.size());
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (i >= bytes.size() || bytes[i] !== exp[i]) begin
        failures++;
        $display("FAIL prio_byte%0d: got %h required %h", i,
                 (i < bytes.size()) ? bytes[i] : 8'hxx, exp[i]);
      end
    end
    checks++;
    if (start_cyc.size() < 6 || fdone_cyc.size() < 1 || start_cyc[0] != e + 18 ||
        start_cyc[5] != fdone_cyc[0] + 3) begin
      failures++;
      $display("FAIL prio_timing: got first=%0d second-after-done=%0d required 18 and 3",
               (start_cyc.size() > 0) ? start_cyc[0] - e : -1,
               (start_cyc.size() > 5 && fdone_cyc.size() > 0) ? start_cyc[5] - fdone_cyc[0] : -1);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] exp [5];
    bit ok;
    exp = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h13};
    do_reset();
    enable = 1'b0; uart_on = 1'b1; uart_delay = 4;
    evt_req = 1'b1; evt_code = 8'h55;
    tick(1);
    evt_req = 1'b0;
    tick(5);
    evt_req = 1'b1; evt_code = 8'h11;
    tick(1);
    evt_req = 1'b0;
    tick(1);
    checks++;
    if (evt_overrun !== 1'b0) begin
      failures++;
      $display("FAIL ovr_first: got %b required 0", evt_overrun);
    end
    tick(1);
    evt_req = 1'b1; evt_code = 8'h22;
    tick(1);
    evt_req = 1'b0; evt_code = 8'h00;
    tick(1);
    checks++;
    if (evt_overrun !== 1'b1) begin
      failures++;
      $display("FAIL ovr_second: got %b required 1", evt_overrun);
    end
    wait_frames(2, 200, ok);
    tick(40);
    checks++;
    if (!ok || bytes.size() != 10) begin
      failures++;
      $display("FAIL ovr_count: got %0d bytes required 10", bytes.size());
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i + 5 >= bytes.size() || bytes[i + 5] !== exp[i]) begin
        failures++;
        $display("FAIL ovr_byte%0d: got %h required %h", i,
                 (i + 5 < bytes.size()) ? bytes[i + 5] : 8'hxx, exp[i]);
      end
    end
    checks++;
    if (evt_overrun !== 1'b1) begin
      failures++;
      $display("FAIL ovr_sticky: got %b required 1", evt_overrun);
    end
    do_reset();
    checks++;
    if (evt_overrun !== 1'b0) begin
      failures++;
      $display("FAIL ovr_rst: got %b required 0", evt_overrun);
    end
  endtask

  task automatic test_reset_mid_frame();
    int k;
    do_reset();
    enable = 1'b0; uart_on = 1'b1; uart_delay = 10;
    evt_req = 1'b1; evt_code = 8'h77;
    tick(1);
    evt_req = 1'b0;
    k = 0;
    while (bytes.size() < 3 && k < 100) begin
      tick(1);
      k++;
    end
    tick(3);
    evt_req = 1'b1; evt_code = 8'h66;
    tick(1);
    evt_req = 1'b0;
    uart_on = 1'b0;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checks++;
    if (bytes.size() != 3 || {tx_start, busy, frame_done, evt_overrun} !== 4'b0000 || tx_data !== 8'h00) begin
      failures++;
      $display("FAIL midrst_out: got bytes=%0d ctrl=%b data=%h required 3 0000 00", bytes.size(),
               {tx_start, busy, frame_done, evt_overrun}, tx_data);
    end
    manual_done = 1'b1;
    tick(1);
    manual_done = 1'b0;
    tick(30);
    checks++;
    if (bytes.size() != 3 || busy !== 1'b0 || fdone_cyc.size() != 0) begin
      failures++;
      $display("FAIL midrst_quiet: got bytes=%0d busy=%b fdone=%0d required 3 0 0",
               bytes.size(), busy, fdone_cyc.size());
    end
    uart_on = 1'b1;
  endtask

  task automatic test_payload_freeze();
    logic [7:0] exp [5];
    logic [7:0] held;
    int unstable;
    int k;
    int hold;
    exp = '{8'hA5, 8'h01, 8'hC3, 8'hA1, 8'h63};
    unstable = 0;
    uart_on = 1'b0;
    do_reset();
    tel_data = 16'hC3A1;
    enable = 1'b1;
    tick(PERIOD);
    enable = 1'b0;
    for (int b = 0; b < 5; b++) begin
      k = 0;
      while (tx_start !== 1'b1 && k < 20) begin
        tick(1);
        k++;
      end
      checks++;
      if (tx_start !== 1'b1) begin
        failures++;
        $display("FAIL freeze_start%0d: got tx_start=%b required 1", b, tx_start);
      end
      held = tx_data;
      tick(1);
      hold = (b == 0) ? 200 : 3;
      for (int h = 0; h < hold; h++) begin
        tel_data = tel_data + 16'h1111;
        if (tx_data !== held || tx_start !== 1'b0) unstable++;
        tick(1);
      end
      manual_done = 1'b1;
      tick(1);
      manual_done = 1'b0;
    end
    tick(10);
    checks++;
    if (unstable != 0) begin
      failures++;
      $display("FAIL freeze_stable: got %0d unstable cycles required 0", unstable);
    end
    checks++;
    if (bytes.size() != 5 || fdone_cyc.size() != 1) begin
      failures++;
      $display("FAIL freeze_count: got %0d starts %0d frame_done required 5 and 1",
               bytes.size(), fdone_cyc.size());
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= bytes.size() || bytes[i] !== exp[i]) begin
        failures++;
        $display("FAIL freeze_byte%0d: got %h required %h", i,
                 (i < bytes.size()) ? bytes[i] : 8'hxx, exp[i]);
      end
    end
    uart_on = 1'b1;
  endtask

  initial begin
    test_reset();
    test_event_frame();
    test_periodic();
    test_priority();
    test_overrun();
    test_reset_mid_frame();
    test_payload_freeze();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_frame_scheduler.md
Name: uart_frame_scheduler

Overview:
Shares the controller's single byte-level UART transmitter between two requesters: a periodic telemetry report and an asynchronous event report. Latches requests, arbitrates with event priority, and sequences each winner into a fixed 5-byte framed packet. Drives the UART's start/done handshake one byte at a time. Sits between the motor-control core and the uart_tx instance that feeds uartTx/TxDone.

Parameters:
REPORT_PERIOD, 5_000_000, clock cycles between telemetry requests (100 ms at 50 MHz); legal range 8..2^24-1
HEADER, 8'hA5, frame sync byte

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
enable  in  1  1 = periodic telemetry timer runs
tel_data  in  16  telemetry value (speed/encoder count), sampled once at frame load
evt_req  in  1  single-cycle event request pulse
evt_code  in  8  event code, sampled in the same cycle as evt_req
tx_data  out  8  byte presented to the UART
tx_start  out  1  one-cycle pulse: UART begins sending tx_data
tx_done  in  1  one-cycle pulse from UART: current byte finished
busy  out  1  high from LOAD through DONE
frame_done  out  1  one-cycle pulse after the 5th byte's tx_done
evt_overrun  out  1  sticky: an event was dropped

Behaviour:
- Reset (clk edge with rst=1): state IDLE; tx_data=0, tx_start=0, busy=0, frame_done=0, evt_overrun=0; timer=0; tel_pend=0, evt_pend=0, evt_latched=0, idx=0. Reset overrides everything, including a frame in progress; the partial frame is abandoned with no further tx_start.
- Timer: when enable=1, it counts 0..REPORT_PERIOD-1 and wraps. On the wrap cycle it sets tel_pend. When enable=0, the timer is held at 0 and tel_pend is not set; an existing tel_pend is kept. A frame in progress always completes regardless of enable.
- Event latch: evt_req=1 with evt_pend=0 sets evt_pend and stores evt_code. evt_req=1 with evt_pend=1 keeps the stored code, drops the new one, and sets evt_overrun (sticky until rst). If evt_req arrives in the same cycle that LOAD clears evt_pend, the new request is latched with no overrun.
- If the timer wrap hits while tel_pend=1, it is absorbed: no queueing and no overrun.
- FSM states: IDLE, LOAD, SEND, WAIT, DONE.
  - IDLE: if evt_pend or tel_pend, go to LOAD; otherwise stay.
  - LOAD: select event if evt_pend=1, else telemetry. Clear only the selected pend flag. Capture the 4 payload bytes. idx=0. Go to SEND.
  - SEND: tx_start=1 for exactly this cycle; tx_data=byte[idx]. Go to WAIT.
  - WAIT: tx_data held stable. On tx_done: if idx=4 go to DONE, else idx+1 and go to SEND.
  - DONE: frame_done=1 for one cycle. Go to IDLE.
- tx_done outside WAIT is ignored. tx_start is never asserted outside SEND.
- Frame bytes:
  - byte0 = HEADER
  - byte1 = type: 8'h01 for telemetry, 8'h02 for event
  - byte2 = tel_data[15:8] for telemetry, 8'h00 for event
  - byte3 = tel_data[7:0] for telemetry, evt_code for event
  - byte4 = byte1 ^ byte2 ^ byte3
- Payload is frozen at LOAD; later changes to tel_data do not affect the frame in flight.
- Latency:
  - evt_req sampled at edge N in IDLE: LOAD in cycle N+2, first tx_start in cycle N+3.
  - tx_done in WAIT at cycle M: next tx_start at M+1 (or frame_done at M+1 after byte4).
  - Min frame length = 5 UART byte times + 7 cycles of overhead.
- Arbitration: a pending event always wins the next LOAD; telemetry waits. A frame in progress is never pre-empted.
- busy=1 in LOAD, SEND, WAIT, DONE.

Test Plan:
- Event frame: rst, enable=0, evt_req with evt_code=8'h3C; UART model returns tx_done 10 cycles after each tx_start -> bytes A5 02 00 3C 3E; first tx_start 3 cycles after evt_req; frame_done once; evt_overrun=0.
- Periodic telemetry: REPORT_PERIOD=16, enable=1, tel_data=16'h1234 -> frame A5 01 12 34 27 starts after the 16th enabled cycle; with an instant UART it repeats every 16 cycles.
- Priority/collision: tel_pend and evt_pend both set while IDLE -> event frame first, then telemetry frame immediately after DONE/IDLE; no bytes interleaved.
- Overrun: two evt_req pulses (codes 8'h11, then 8'h22) during one in-flight frame -> only the 8'h11 frame follows; evt_overrun=1 and stays 1 until rst.
- Reset mid-frame: assert rst in WAIT after byte2 -> next cycle all outputs 0, state IDLE; a spurious tx_done after reset produces no tx_start; pend flags cleared.
- Payload freeze/handshake: change tel_data every cycle during a frame and hold tx_done low for 200 cycles in WAIT -> bytes match the value at LOAD, tx_data stays stable, and exactly one tx_start per byte.
